data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_align.sv | 82 ++++++++
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data memory responder:
//   - access size encodings carried on req_size
//   - responder FSM state encoding
//   - latched request record
//   - default DEPTH / LATENCY values and the latency counter width
//   - size_mask(): contiguous byte-enable pattern for an access size
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DEFAULT_DEPTH   = 32;  // 64-bit doublewords held
  localparam int DEFAULT_LATENCY = 2;   // accept-to-response cycles, 1..15
  localparam int CNT_W           = 4;   // wide enough for LATENCY-1 up to 14

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request fields captured on the accept handshake and held until the
  // response is consumed.
  typedef struct packed {
    logic        we;
    size_e       size;
    logic        is_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  // Byte-enable pattern for lane 0; the caller shifts it to the target lane.
  function automatic logic [7:0] size_mask(input size_e size);
    logic [7:0] mask;
    unique case (size)
      SIZE_BYTE:  mask = 8'h01;
      SIZE_HALF:  mask = 8'h03;
      SIZE_WORD:  mask = 8'h0F;
      SIZE_DWORD: mask = 8'hFF;
      default:    mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// -----------------------------------------------------------------------------
// dmem_align
// Purely combinational lane logic for one memory access.
//   size, is_unsigned   access size and load extension mode
//   addr                byte address (full 64 bits, used for the range check)
//   wdata               store data, right-justified
//   dword               current contents of the addressed doubleword
//   err                 misaligned for the size, or addr beyond DEPTH*8 bytes
//   byte_en             lanes written by a store
//   wdata_lane          store data moved onto its lanes
//   rdata               load data pulled from its lanes and extended to 64 bits
// -----------------------------------------------------------------------------
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [63:0] dword,
  output logic        err,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata
);

  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  logic [2:0]  lane;
  logic [5:0]  shamt;
  logic        misaligned;
  logic        out_of_range;
  logic [63:0] shifted;

  // Little-endian: the low three address bits pick the first byte lane.
  assign lane  = addr[2:0];
  assign shamt = {lane, 3'b000};

  // NOTE: every output of a combinational block is given a value on every
  // path (default first), otherwise synthesis infers a latch.
  always_comb begin
    misaligned = 1'b0;
    unique case (size)
      SIZE_BYTE:  misaligned = 1'b0;
      SIZE_HALF:  misaligned = addr[0];
      SIZE_WORD:  misaligned = |addr[1:0];
      SIZE_DWORD: misaligned = |addr[2:0];
      default:    misaligned = 1'b1;
    endcase
  end

  assign out_of_range = (addr >= LIMIT);
  assign err          = misaligned | out_of_range;

  // Bits pushed past lane 7 only occur on misaligned accesses, which are
  // flagged as errors and never written.
  assign byte_en    = size_mask(size) << lane;
  assign wdata_lane = wdata << shamt;
  assign shifted    = dword >> shamt;

  always_comb begin
    rdata = shifted;
    unique case (size)
      SIZE_BYTE:
        rdata = is_unsigned ? {56'd0, shifted[7:0]}
                            : {{56{shifted[7]}}, shifted[7:0]};
      SIZE_HALF:
        rdata = is_unsigned ? {48'd0, shifted[15:0]}
                            : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_WORD:
        rdata = is_unsigned ? {32'd0, shifted[31:0]}
                            : {{32{shifted[31]}}, shifted[31:0]};
      SIZE_DWORD:
        rdata = shifted;  // full width, extension mode is irrelevant
      default:
        rdata = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Fixed-latency data memory slave for a pipeline MEM stage. One request is
// outstanding at a time: IDLE accepts, WAIT counts LATENCY-1 down to 0, RESP
// holds the response until the pipeline takes it. Stores commit and loads read
// on the WAIT -> RESP edge.
//
// Parameters
//   DEPTH    number of 64-bit doublewords (at least 3)
//   LATENCY  cycles from accept edge to rsp_valid, 1..15
// Ports
//   clk, reset                       clock; asynchronous active-low reset
//   req_valid / req_ready            request handshake
//   req_we, req_size, req_unsigned   store flag, access size, load extension
//   req_addr, req_wdata              byte address, right-justified store data
//   rsp_valid / rsp_ready            response handshake
//   rsp_rdata, rsp_err               extended load data, error flag
//   element1..element3               live contents of doublewords 0..2
// -----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] element1,
  output logic [63:0] element2,
  output logic [63:0] element3
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req_q;
  logic [63:0]      mem [DEPTH];

  logic             accept;
  logic             commit;
  logic [IDX_W-1:0] idx;

  logic             align_err;
  logic [7:0]       byte_en;
  logic [63:0]      wdata_lane;
  logic [63:0]      load_data;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (req_valid)      state_next = ST_WAIT;
      ST_WAIT: if (cnt == '0)      state_next = ST_RESP;
      ST_RESP: if (rsp_ready)      state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  assign accept = req_valid && req_ready;
  // Last WAIT cycle: the edge that ends it performs the access.
  assign commit = (state == ST_WAIT) && (cnt == '0);

  // ---------------------------------------------------------------------------
  // Request capture and latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      req_q <= '0;
    end else if (accept) begin
      cnt   <= CNT_LOAD;
      req_q <= '{we:          req_we,
                 size:        size_e'(req_size),
                 is_unsigned: req_unsigned,
                 addr:        req_addr,
                 wdata:       req_wdata};
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane logic on the latched request
  // ---------------------------------------------------------------------------
  // Out-of-range addresses alias onto a valid index here, but those requests
  // carry align_err and are never written or returned.
  assign idx = req_q.addr[IDX_W+2:3];

  dmem_align #(
    .DEPTH (DEPTH)
  ) u_align (
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .addr        (req_q.addr),
    .wdata       (req_q.wdata),
    .dword       (mem[idx]),
    .err         (align_err),
    .byte_en     (byte_en),
    .wdata_lane  (wdata_lane),
    .rdata       (load_data)
  );

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array is reset because its contents are architecturally visible
  // (element1..3 must read zero out of reset); a plain RAM macro would not be.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && req_q.we && !align_err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign element1 = mem[0];
  assign element2 = mem[1];
  assign element3 = mem[2];

  // ---------------------------------------------------------------------------
  // Response registers: loaded once on the commit edge, then held through RESP
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= align_err;
      rsp_rdata <= (align_err || req_q.we) ? 64'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder (DEPTH 32, LATENCY 2). A byte-wide
// reference memory predicts each response when the request is driven; the
// prediction is queued and compared when the response handshake occurs.
// Inputs change 1 ns after the rising edge; outputs are sampled at the falling
// edge by the monitor and at 1 ns after the rising edge by the tests.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH   = 32;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] element1;
  logic [63:0] element2;
  logic [63:0] element3;

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .element1     (element1),
    .element2     (element2),
    .element3     (element3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   acc_cycle = -1;
  int   hs_cycle  = -1;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] model_mem [DEPTH*8];

  always @(posedge clk) cycle++;

  // Monitor: records handshake edges and scores every consumed response.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cycle = cycle + 1;
    if (rsp_valid && rsp_ready) begin
      hs_cycle = cycle + 1;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b with nothing expected", rsp_rdata, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
          fails++;
          $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [63:0] addr, input logic [63:0] wdata);
    int          n = 1 << size;
    logic [63:0] v = '0;
    exp_t        e;
    if ((addr % n) != 0 || addr >= DEPTH*8) begin
      e = '{rdata: 64'd0, err: 1'b1};
    end else if (we) begin
      for (int i = 0; i < n; i++) model_mem[addr + i] = wdata[8*i +: 8];
      e = '{rdata: 64'd0, err: 1'b0};
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[addr + i];
      if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e = '{rdata: v, err: 1'b0};
    end
    sb.push_back(e);
  endfunction

  function automatic logic [63:0] model_dw(input int k);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = model_mem[8*k + i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request/response. stall = cycles rsp_ready stays low in RESP;
  // junk = present an extra store to doubleword 2 while stalled.
  task automatic transact(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input int stall, input bit junk);
    int          n;
    logic [63:0] r0;
    logic        e0;
    n = 0;
    while (!req_ready && n < 100) begin step(); n++; end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL req_ready_timeout: addr=%h req_ready=%b after %0d cycles, expected 1", addr, req_ready, n);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    model_req(we, size, uns, addr, wdata);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    tests++;
    if (n != LATENCY) begin
      fails++;
      $display("FAIL latency: addr=%h rsp_valid after %0d cycles, expected %0d", addr, n, LATENCY);
    end
    r0 = rsp_rdata;
    e0 = rsp_err;
    if (junk) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
      req_addr = 64'h10; req_wdata = '1;
    end
    for (int i = 0; i < stall; i++) begin
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d valid=%b rdata=%h err=%b req_ready=%b, expected 1 %h %b 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_handshake: rsp_valid=%b req_ready=%b, expected 0 1", rsp_valid, req_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH*8; i++) model_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, expected 1 0", req_ready, rsp_valid);
    end
    tests++;
    if (rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp: rdata=%h err=%b, expected 0 0", rsp_rdata, rsp_err);
    end
    tests++;
    if (element1 !== 64'd0 || element2 !== 64'd0 || element3 !== 64'd0) begin
      fails++;
      $display("FAIL reset_elements: %h %h %h, expected all 0", element1, element2, element3);
    end
  endtask

  task automatic test_store_load();
    transact(1'b1, 2'b11, 1'b0, 64'h0, 64'h1122334455667788, 0, 1'b0);
    tests++;
    if (element1 !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL sd_element1: got %h, expected 1122334455667788", element1);
    end
    transact(1'b0, 2'b00, 1'b0, 64'h7, 64'h0, 0, 1'b0);              // lb 7 -> 0x11
    transact(1'b1, 2'b00, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FF80, 0, 1'b0); // sb 7 <- 0x80
    transact(1'b0, 2'b10, 1'b0, 64'h4, 64'h0, 0, 1'b0);              // lw 4 signed
    transact(1'b0, 2'b01, 1'b1, 64'h6, 64'h0, 0, 1'b0);              // lhu 6
    transact(1'b0, 2'b00, 1'b0, 64'h7, 64'h0, 0, 1'b0);              // lb 7 signed, negative
    transact(1'b0, 2'b00, 1'b1, 64'h0, 64'h0, 0, 1'b0);              // lbu 0
    transact(1'b0, 2'b11, 1'b1, 64'h0, 64'h0, 0, 1'b0);              // ld ignores unsigned
    tests++;
    if (element1 !== model_dw(0)) begin
      fails++;
      $display("FAIL sb_element1: got %h, expected %h", element1, model_dw(0));
    end
  endtask

  task automatic test_errors();
    transact(1'b0, 2'b01, 1'b0, 64'h3, 64'h0, 0, 1'b0);              // lh misaligned
    transact(1'b1, 2'b10, 1'b0, 64'h2, 64'hDEAD_BEEF, 0, 1'b0);      // sw misaligned
    transact(1'b1, 2'b11, 1'b0, 64'h100, 64'hCAFE_CAFE_CAFE_CAFE, 0, 1'b0); // past end
    tests++;
    if (element1 !== model_dw(0) || element2 !== 64'd0) begin
      fails++;
      $display("FAIL err_no_write: element1=%h element2=%h, expected %h 0", element1, element2, model_dw(0));
    end
    transact(1'b1, 2'b00, 1'b0, 64'hFF, 64'hAB, 0, 1'b0);            // last valid byte
    transact(1'b0, 2'b11, 1'b0, 64'hF8, 64'h0, 0, 1'b0);             // last doubleword
    transact(1'b0, 2'b00, 1'b0, 64'h100, 64'h0, 0, 1'b0);            // first invalid byte
  endtask

  task automatic test_backpressure();
    transact(1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 5, 1'b1);
    tests++;
    if (element3 !== model_dw(2)) begin
      fails++;
      $display("FAIL stall_ignored_req: element3=%h, expected %h", element3, model_dw(2));
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h8; req_wdata = 64'hAA;
    step();
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < DEPTH*8; i++) model_mem[i] = 8'h00;
    tests++;
    if (element2 !== 64'd0 || rsp_valid !== 1'b0 || element1 !== 64'd0) begin
      fails++;
      $display("FAIL abort_async: element1=%h element2=%h rsp_valid=%b, expected 0 0 0",
               element1, element2, rsp_valid);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < LATENCY + 3; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    tests++;
    if (seen || req_ready !== 1'b1 || element2 !== 64'd0) begin
      fails++;
      $display("FAIL abort_after: rsp_seen=%b req_ready=%b element2=%h, expected 0 1 0",
               seen, req_ready, element2);
    end
  endtask

  task automatic test_back_to_back();
    int a1;
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h10; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    model_req(1'b1, 2'b11, 1'b0, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    a1 = acc_cycle;
    req_we = 1'b0; req_wdata = '0;
    model_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
    n = 0;
    while (acc_cycle == a1 && n < 50) begin step(); n++; end
    req_valid = 1'b0;
    tests++;
    if (acc_cycle != hs_cycle + 1) begin
      fails++;
      $display("FAIL b2b_accept: second accept at cycle %0d, expected %0d", acc_cycle, hs_cycle + 1);
    end
    n = 0;
    while (sb.size() != 0 && n < 50) begin step(); n++; end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: %0d responses outstanding, expected 0", sb.size());
    end
    tests++;
    if (element3 !== 64'hDEAD_BEEF_CAFE_F00D) begin
      fails++;
      $display("FAIL b2b_element3: got %h, expected deadbeefcafef00d", element3);
    end
    rsp_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: %0d expected responses never seen", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
